// File: rtl/icache_2way.sv
// icache_2way: two-way set-associative, read-only instruction cache.
// Per-set LRU replacement, registered refill controller with a latched miss
// address, and a SETS-cycle flush that walks every set clearing valid and lru.
module icache_2way #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SETS   = 8,
  parameter int unsigned WORDS  = 4,
  localparam int unsigned OFF_W = $clog2(WORDS),
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W,
  localparam int unsigned BLK_W = ADDR_W - 2 - OFF_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                cpu_read,
  input  logic                flush,
  output logic [31:0]         instruction,
  output logic                busywait,
  output logic                hit,
  output logic                mem_read,
  output logic [BLK_W-1:0]    mem_address,
  input  logic [32*WORDS-1:0] mem_readdata,
  input  logic                mem_busywait
);

  typedef logic [WORDS-1:0][31:0] line_t;
  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

  state_t state, state_next;

  line_t            data0 [SETS];
  line_t            data1 [SETS];
  logic [TAG_W-1:0] tag0  [SETS];
  logic [TAG_W-1:0] tag1  [SETS];
  logic [SETS-1:0]  valid0;
  logic [SETS-1:0]  valid1;
  logic [SETS-1:0]  lru;

  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [IDX_W-1:0] flush_cnt;
  logic             flush_pending;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             match0;
  logic             match1;
  logic             victim;

  logic             fill;
  logic             hit_upd;
  logic             miss_latch;
  logic             flush_clr;
  logic             pend_set;
  logic             pend_clr;

  logic             unused_pc_bits;

  // Address decode and tag compare for the current pc
  assign offset = pc[OFF_W+1:2];
  assign idx    = pc[OFF_W+IDX_W+1:OFF_W+2];
  assign tag    = pc[ADDR_W-1:ADDR_W-TAG_W];
  assign match0 = valid0[idx] && (tag0[idx] == tag);
  assign match1 = valid1[idx] && (tag1[idx] == tag);
  assign unused_pc_bits = ^pc[1:0];

  // Fill empty ways in order, otherwise replace the way lru names
  assign victim = valid0[miss_idx] ? (valid1[miss_idx] ? lru[miss_idx] : 1'b1) : 1'b0;

  assign mem_address = {miss_tag, miss_idx};

  // Next-state and output decode; everything stays quiet while reset is held
  always_comb begin
    state_next  = state;
    hit         = 1'b0;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    instruction = '0;
    fill        = 1'b0;
    hit_upd     = 1'b0;
    miss_latch  = 1'b0;
    flush_clr   = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (cpu_read) begin
            if (match0 || match1) begin
              hit         = 1'b1;
              instruction = match1 ? data1[idx][offset] : data0[idx][offset];
              hit_upd     = 1'b1;
            end else begin
              busywait = 1'b1;
              if (!flush) begin
                miss_latch = 1'b1;
                state_next = REFILL;
              end
            end
          end
          if (flush) begin
            state_next = FLUSH;
          end
        end
        REFILL: begin
          mem_read = 1'b1;
          busywait = 1'b1;
          if (flush) begin
            pend_set = 1'b1;
          end
          if (!mem_busywait) begin
            fill       = 1'b1;
            pend_clr   = 1'b1;
            state_next = (flush || flush_pending) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          busywait  = 1'b1;
          flush_clr = 1'b1;
          if (flush_cnt == IDX_W'(SETS - 1)) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Controller state, flush walk counter and latched miss address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      flush_cnt     <= '0;
      miss_tag      <= '0;
      miss_idx      <= '0;
    end else begin
      state <= state_next;
      if (pend_clr) begin
        flush_pending <= 1'b0;
      end else if (pend_set) begin
        flush_pending <= 1'b1;
      end
      if (flush_clr) begin
        flush_cnt <= flush_cnt + IDX_W'(1);
      end
      if (miss_latch) begin
        miss_tag <= tag;
        miss_idx <= idx;
      end
    end
  end

  // Valid and lru bookkeeping: flush walk, refill install, hit touch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (flush_clr) begin
      valid0[flush_cnt] <= 1'b0;
      valid1[flush_cnt] <= 1'b0;
      lru[flush_cnt]    <= 1'b0;
    end else if (fill) begin
      if (victim) begin
        valid1[miss_idx] <= 1'b1;
      end else begin
        valid0[miss_idx] <= 1'b1;
      end
      lru[miss_idx] <= ~victim;
    end else if (hit_upd) begin
      lru[idx] <= ~match1;
    end
  end

  // Line data and tag storage, written only by a completing refill
  always_ff @(posedge clock) begin
    if (fill) begin
      if (victim) begin
        data1[miss_idx] <= mem_readdata;
        tag1[miss_idx]  <= miss_tag;
      end else begin
        data0[miss_idx] <= mem_readdata;
        tag0[miss_idx]  <= miss_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// tb_icache_2way: random and directed fetches against a recency-list model
// of a 2-way LRU cache, with a latency-programmable line memory.
module tb_icache_2way;

  logic         clock;
  logic         reset;
  logic [31:0]  pc;
  logic         cpu_read;
  logic         flush;
  logic [31:0]  instruction;
  logic         busywait;
  logic         hit;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int total = 0;
  int bad   = 0;
  int lat   = 5;
  int mcnt;

  // Model: per set, resident tags ordered oldest first
  logic [24:0] m_tags [8][2];
  int          m_cnt  [8];

  icache_2way dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .cpu_read     (cpu_read),
    .flush        (flush),
    .instruction  (instruction),
    .busywait     (busywait),
    .hit          (hit),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input int w);
    return (32'(blk) * 32'h9E37_79B1) ^ (32'(w) << 28) ^ 32'h0F1E_2D3C;
  endfunction

  // Memory holds busywait for lat cycles of mem_read, then completes
  always @(posedge clock or negedge reset) begin
    if (!reset) mcnt <= 0;
    else if (mem_read) mcnt <= (mcnt == lat) ? 0 : mcnt + 1;
    else mcnt <= 0;
  end
  assign mem_busywait = !(mem_read && (mcnt == lat));

  always_comb begin
    mem_readdata = '0;
    for (int w = 0; w < 4; w++) mem_readdata[w*32 +: 32] = mem_word(mem_address, w);
  end

  function automatic bit model_hit(input logic [31:0] a);
    int s = int'((a >> 4) & 32'd7);
    logic [24:0] t = 25'(a >> 7);
    for (int i = 0; i < m_cnt[s]; i++) if (m_tags[s][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_access(input logic [31:0] a);
    int s = int'((a >> 4) & 32'd7);
    logic [24:0] t = 25'(a >> 7);
    int p = -1;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tags[s][i] == t) p = i;
    if (p < 0 && m_cnt[s] == 2) p = 0;
    if (p >= 0) begin
      for (int i = p; i < m_cnt[s] - 1; i++) m_tags[s][i] = m_tags[s][i+1];
      m_cnt[s] = m_cnt[s] - 1;
    end
    m_tags[s][m_cnt[s]] = t;
    m_cnt[s] = m_cnt[s] + 1;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) m_cnt[s] = 0;
  endfunction

  // One fetch: zero-latency hit or miss -> refill -> hit, checked against the model
  task automatic fetch(input logic [31:0] addr, output bit was_hit);
    bit exp_hit;
    logic [31:0] exp_w;
    int stall;
    bit saw_req;
    exp_hit = model_hit(addr);
    exp_w   = mem_word(28'(addr >> 4), int'((addr >> 2) & 32'd3));
    @(negedge clock);
    pc = addr;
    cpu_read = 1'b1;
    #1;
    was_hit = hit;
    total++;
    if (hit !== exp_hit) begin
      bad++;
      $display("FAIL lookup_hit addr=%h got %b want %b", addr, hit, exp_hit);
    end
    if (exp_hit) begin
      total++;
      if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== exp_w) begin
        bad++;
        $display("FAIL hit_data addr=%h got bw=%b mr=%b instr=%h want bw=0 mr=0 instr=%h",
                 addr, busywait, mem_read, instruction, exp_w);
      end
    end else begin
      total++;
      if (busywait !== 1'b1) begin
        bad++;
        $display("FAIL miss_stall addr=%h got busywait=%b want 1", addr, busywait);
      end
      stall = 0;
      saw_req = 1'b0;
      while (busywait === 1'b1 && stall < 200) begin
        @(negedge clock);
        #1;
        stall++;
        if (!saw_req && mem_read === 1'b1) begin
          saw_req = 1'b1;
          total++;
          if (mem_address !== 28'(addr >> 4)) begin
            bad++;
            $display("FAIL mem_address addr=%h got %h want %h", addr, mem_address, 28'(addr >> 4));
          end
        end
      end
      total++;
      if (!saw_req) begin
        bad++;
        $display("FAIL mem_read_req addr=%h got no mem_read want mem_read=1", addr);
      end
      total++;
      if (stall != lat + 2) begin
        bad++;
        $display("FAIL miss_latency addr=%h got %0d want %0d", addr, stall, lat + 2);
      end
      total++;
      if (hit !== 1'b1 || instruction !== exp_w) begin
        bad++;
        $display("FAIL refill_hit addr=%h got hit=%b instr=%h want hit=1 instr=%h",
                 addr, hit, instruction, exp_w);
      end
    end
    model_access(addr);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cpu_read = 1'b1;
    pc = 32'h40;
    flush = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (busywait !== 1'b0 || hit !== 1'b0) begin
      bad++;
      $display("FAIL reset_bw_hit got bw=%b hit=%b want 0 0", busywait, hit);
    end
    total++;
    if (mem_read !== 1'b0 || mem_address !== 28'h0) begin
      bad++;
      $display("FAIL reset_mem got mr=%b addr=%h want 0 0", mem_read, mem_address);
    end
    cpu_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if (busywait !== 1'b0 || mem_read !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got bw=%b mr=%b want 0 0", busywait, mem_read);
    end
  endtask

  task automatic test_cold_miss;
    bit h;
    lat = 5;
    fetch(32'h40, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL cold_miss got hit=%b want 0", h);
    end
  endtask

  task automatic test_same_line;
    bit h;
    fetch(32'h4C, h);
    total++;
    if (h !== 1'b1) begin
      bad++;
      $display("FAIL same_line got hit=%b want 1", h);
    end
  endtask

  task automatic test_two_way;
    bit h0, h1, h2;
    lat = 3;
    fetch(32'hC0, h0);
    fetch(32'h40, h1);
    fetch(32'hC0, h2);
    total++;
    if (h0 !== 1'b0 || h1 !== 1'b1 || h2 !== 1'b1) begin
      bad++;
      $display("FAIL two_way got %b%b%b want 011", h0, h1, h2);
    end
  endtask

  task automatic test_lru_evict;
    bit h0, h1, h2, h3;
    lat = 2;
    fetch(32'h40, h0);
    fetch(32'h140, h1);
    fetch(32'h40, h2);
    fetch(32'hC0, h3);
    total++;
    if (h0 !== 1'b1 || h1 !== 1'b0 || h2 !== 1'b1 || h3 !== 1'b0) begin
      bad++;
      $display("FAIL lru_evict got %b%b%b%b want 1010", h0, h1, h2, h3);
    end
  endtask

  task automatic test_flush;
    bit h;
    int n;
    @(negedge clock);
    pc = 32'h40;
    cpu_read = 1'b1;
    flush = 1'b1;
    #1;
    total++;
    if (hit !== 1'b1 || busywait !== 1'b0) begin
      bad++;
      $display("FAIL flush_hit_served got hit=%b bw=%b want 1 0", hit, busywait);
    end
    model_access(32'h40);
    @(negedge clock);
    flush = 1'b0;
    cpu_read = 1'b0;
    #1;
    n = 0;
    while (busywait === 1'b1 && n < 100) begin
      n++;
      flush = (n == 4);
      @(negedge clock);
      #1;
    end
    flush = 1'b0;
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL flush_cycles got %0d want 8", n);
    end
    model_clear();
    lat = 1;
    fetch(32'h40, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL after_flush got hit=%b want 0", h);
    end
  endtask

  task automatic test_flush_in_refill;
    bit h;
    int n, mr;
    lat = 4;
    @(negedge clock);
    pc = 32'h240;
    cpu_read = 1'b1;
    #1;
    total++;
    if (busywait !== 1'b1) begin
      bad++;
      $display("FAIL fir_miss got bw=%b want 1", busywait);
    end
    @(negedge clock);
    #1;
    total++;
    if (mem_read !== 1'b1) begin
      bad++;
      $display("FAIL fir_refill got mr=%b want 1", mem_read);
    end
    flush = 1'b1;
    cpu_read = 1'b0;
    pc = 32'h1234;
    @(negedge clock);
    flush = 1'b0;
    #1;
    n = 0;
    mr = 0;
    while (busywait === 1'b1 && n < 100) begin
      n++;
      if (mem_read === 1'b1) mr++;
      @(negedge clock);
      #1;
    end
    total++;
    if (n != lat + 8) begin
      bad++;
      $display("FAIL fir_stall got %0d want %0d", n, lat + 8);
    end
    total++;
    if (mr != lat) begin
      bad++;
      $display("FAIL fir_mem_read got %0d want %0d", mr, lat);
    end
    model_clear();
    fetch(32'h40, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL fir_after got hit=%b want 0", h);
    end
  endtask

  task automatic test_reset_in_refill;
    bit h;
    lat = 6;
    @(negedge clock);
    pc = 32'h340;
    cpu_read = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    total++;
    if (mem_read !== 1'b1 || busywait !== 1'b1) begin
      bad++;
      $display("FAIL rir_refill got mr=%b bw=%b want 1 1", mem_read, busywait);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (mem_read !== 1'b0 || busywait !== 1'b0 || hit !== 1'b0) begin
      bad++;
      $display("FAIL rir_abort got mr=%b bw=%b hit=%b want 0 0 0", mem_read, busywait, hit);
    end
    total++;
    if (mem_address !== 28'h0) begin
      bad++;
      $display("FAIL rir_addr got %h want 0", mem_address);
    end
    @(negedge clock);
    cpu_read = 1'b0;
    reset = 1'b1;
    model_clear();
    lat = 3;
    fetch(32'h40, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL rir_after got hit=%b want 0", h);
    end
    fetch(32'h340, h);
    total++;
    if (h !== 1'b0) begin
      bad++;
      $display("FAIL rir_no_partial got hit=%b want 0", h);
    end
  endtask

  task automatic test_random;
    bit h;
    int n;
    logic [31:0] a;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clock);
        cpu_read = 1'b0;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        n = 0;
        while (busywait === 1'b1 && n < 100) begin
          n++;
          @(negedge clock);
          #1;
        end
        total++;
        if (n != 8) begin
          bad++;
          $display("FAIL rand_flush got %0d want 8", n);
        end
        model_clear();
      end else begin
        lat = int'($urandom_range(0, 6));
        a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
          | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        fetch(a, h);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpu_read = 1'b0;
    flush = 1'b0;
    pc = '0;
    test_reset;
    test_cold_miss;
    test_same_line;
    test_two_way;
    test_lru_evict;
    test_flush;
    test_flush_in_refill;
    test_reset_in_refill;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
